// File: rtl/keccak_padder_param.sv
`default_nettype none
// ============================================================================
// Module   : keccak_padder_param
// Purpose  : Packs user words into one rate-sized block and applies the
//            Keccak / SHA-3 / SHAKE domain pad plus the final 0x80 bit.
// Revision : 1.0  initial parametrised release
// ============================================================================
module keccak_padder_param #(
    parameter int IN_W      = 32,
    parameter int RATE_BITS = 576
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [IN_W-1:0]              in,
    input  logic                         in_ready,
    input  logic                         is_last,
    input  logic [$clog2(IN_W/8)-1:0]    byte_num,
    input  logic [1:0]                   mode,
    output logic                         buffer_full,
    output logic [RATE_BITS-1:0]         out,
    output logic                         out_ready,
    output logic                         out_last,
    input  logic                         f_ack
);

    localparam int WORDS  = RATE_BITS / IN_W;
    localparam int NBYTES = IN_W / 8;
    localparam int CNT_W  = $clog2(WORDS + 1);

    typedef enum logic [0:0] {
        ABSORB = 1'b0,
        PAD    = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 last_q, last_d;
    logic [RATE_BITS-1:0] out_q, out_d;

    logic                 full;
    logic                 accept;
    logic                 shift;
    logic [7:0]           pad_byte;
    logic [IN_W-1:0]      last_word;
    logic [IN_W-1:0]      shift_word;

    assign full        = (cnt_q == CNT_W'(WORDS));
    assign buffer_full = full;
    assign out_ready   = full;
    assign out_last    = full & last_q;
    assign out         = out_q;

    assign accept = (state_q == ABSORB) && in_ready && !full;
    assign shift  = accept || ((state_q == PAD) && !full);

    always_comb begin
        case (mode)
            2'd1:    pad_byte = 8'h06;
            2'd2:    pad_byte = 8'h1F;
            default: pad_byte = 8'h01;
        endcase
    end

    // Keep the valid leading bytes, drop the pad byte right after them, zero the rest.
    always_comb begin
        last_word = '0;
        for (int b = 0; b < NBYTES; b++) begin
            if (b < int'(byte_num)) begin
                last_word[IN_W-1-8*b -: 8] = in[IN_W-1-8*b -: 8];
            end else if (b == int'(byte_num)) begin
                last_word[IN_W-1-8*b -: 8] = pad_byte;
            end
        end
    end

    always_comb begin
        shift_word = '0;
        if (accept) begin
            shift_word = is_last ? last_word : in;
        end
        // The terminating bit can share a byte with the domain pad (e.g. 0x86).
        if (shift && (cnt_q == CNT_W'(WORDS - 1)) && (last_q || (accept && is_last))) begin
            shift_word[7:0] = shift_word[7:0] | 8'h80;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        out_d   = out_q;

        if (shift) begin
            for (int k = 0; k < WORDS; k++) begin
                if (cnt_q == CNT_W'(k)) begin
                    out_d[RATE_BITS-1-k*IN_W -: IN_W] = shift_word;
                end
            end
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (accept && is_last) begin
            last_d  = 1'b1;
            state_d = PAD;
        end

        if (full && f_ack) begin
            cnt_d = '0;
            if (last_q) begin
                last_d  = 1'b0;
                state_d = ABSORB;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ABSORB;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            out_q   <= out_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_keccak_padder_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_keccak_padder_param
// Purpose  : Directed checks of keccak_padder_param at IN_W=32, RATE_BITS=576.
// Revision : 1.0  initial release
// ============================================================================
module tb_keccak_padder_param;

    localparam int IN_W      = 32;
    localparam int RATE_BITS = 576;
    localparam int WORDS     = RATE_BITS / IN_W;

    logic                 clk;
    logic                 reset;
    logic [IN_W-1:0]      in;
    logic                 in_ready;
    logic                 is_last;
    logic [1:0]           byte_num;
    logic [1:0]           mode;
    logic                 buffer_full;
    logic [RATE_BITS-1:0] out;
    logic                 out_ready;
    logic                 out_last;
    logic                 f_ack;

    int n_chk;
    int n_pass;

    keccak_padder_param #(
        .IN_W      (IN_W),
        .RATE_BITS (RATE_BITS)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .in          (in),
        .in_ready    (in_ready),
        .is_last     (is_last),
        .byte_num    (byte_num),
        .mode        (mode),
        .buffer_full (buffer_full),
        .out         (out),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .f_ack       (f_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [RATE_BITS-1:0] got,
                       input logic [RATE_BITS-1:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [IN_W-1:0] w, input logic last,
                        input logic [1:0] bn, input logic [1:0] md);
        in       = w;
        is_last  = last;
        byte_num = bn;
        mode     = md;
        in_ready = 1'b1;
        step();
        in_ready = 1'b0;
        is_last  = 1'b0;
    endtask

    task automatic wait_full(output int n);
        n = 0;
        while (!out_ready && n < 100) begin
            step();
            n++;
        end
        if (!out_ready) chk("timeout_out_ready", 0, 1);
    endtask

    task automatic ack();
        f_ack = 1'b1;
        step();
        f_ack = 1'b0;
    endtask

    function automatic logic [RATE_BITS-1:0] blk2(input logic [IN_W-1:0] s0,
                                                  input logic [IN_W-1:0] s17);
        logic [RATE_BITS-1:0] b;
        b = '0;
        b[RATE_BITS-1 -: IN_W] = s0;
        b[IN_W-1:0]            = s17;
        return b;
    endfunction

    initial begin
        logic [RATE_BITS-1:0] exp;
        int n;
        n_chk    = 0;
        n_pass   = 0;
        reset    = 1'b0;
        in       = '0;
        in_ready = 1'b0;
        is_last  = 1'b0;
        byte_num = '0;
        mode     = '0;
        f_ack    = 1'b0;
        step();
        step();
        chk("rst_out", out, '0);
        chk("rst_full", RATE_BITS'(buffer_full), 0);
        chk("rst_ready", RATE_BITS'(out_ready), 0);
        chk("rst_last", RATE_BITS'(out_last), 0);
        reset = 1'b1;
        step();

        // T1: empty SHA-3 message; 17 pad cycles after the accept edge
        send(32'hDEADBEEF, 1'b1, 2'd0, 2'd1);
        wait_full(n);
        chk("t1_latency", RATE_BITS'(n + 1), 18);
        chk("t1_block", out, blk2(32'h06000000, 32'h00000080));
        chk("t1_last", RATE_BITS'(out_last), 1);
        ack();
        chk("t1_full_after_ack", RATE_BITS'(buffer_full), 0);
        chk("t1_last_after_ack", RATE_BITS'(out_last), 0);

        // T2: Keccak "abc"
        send(32'h61626300, 1'b1, 2'd3, 2'd0);
        wait_full(n);
        chk("t2_block", out, blk2(32'h61626301, 32'h00000080));
        chk("t2_last", RATE_BITS'(out_last), 1);
        ack();

        // T3: pad byte lands in the last slot together with 0x80
        exp = '0;
        for (int i = 0; i < WORDS - 1; i++) begin
            send(32'h10000000 + i, 1'b0, 2'd0, 2'd1);
            exp[RATE_BITS-1-i*IN_W -: IN_W] = 32'h10000000 + i;
        end
        chk("t3_not_full_yet", RATE_BITS'(out_ready), 0);
        send(32'hAABBCC55, 1'b1, 2'd3, 2'd1);
        chk("t3_ready_now", RATE_BITS'(out_ready), 1);
        exp[IN_W-1:0] = 32'hAABBCC86;
        chk("t3_block", out, exp);
        chk("t3_last", RATE_BITS'(out_last), 1);
        ack();

        // T4: full non-final block, input held under back-pressure
        exp = '0;
        for (int i = 0; i < WORDS; i++) begin
            send(32'h20000000 + i, 1'b0, 2'd0, 2'd0);
            exp[RATE_BITS-1-i*IN_W -: IN_W] = 32'h20000000 + i;
        end
        chk("t4_ready", RATE_BITS'(out_ready), 1);
        in       = 32'hCAFE0000;
        is_last  = 1'b0;
        in_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_hold_full", RATE_BITS'(buffer_full), 1);
            chk("t4_hold_last", RATE_BITS'(out_last), 0);
        end
        chk("t4_hold_block", out, exp);
        f_ack = 1'b1;
        step();
        f_ack = 1'b0;
        chk("t4_ack_no_accept", out, exp);
        chk("t4_ack_full", RATE_BITS'(buffer_full), 0);
        step();
        chk("t4_first_word", RATE_BITS'(out[RATE_BITS-1 -: IN_W]), 32'hCAFE0000);
        exp[RATE_BITS-1 -: IN_W] = 32'hCAFE0000;
        for (int i = 1; i < WORDS; i++) begin
            in = 32'hCAFE0000 + i;
            step();
            exp[RATE_BITS-1-i*IN_W -: IN_W] = 32'hCAFE0000 + i;
        end
        in_ready = 1'b0;
        chk("t4_second_ready", RATE_BITS'(out_ready), 1);
        chk("t4_second_block", out, exp);
        chk("t4_second_last", RATE_BITS'(out_last), 0);
        ack();

        // T5: back-to-back SHAKE messages without reset
        send(32'h00000000, 1'b1, 2'd0, 2'd2);
        wait_full(n);
        chk("t5_blockA", out, blk2(32'h1F000000, 32'h00000080));
        ack();
        chk("t5_open", RATE_BITS'(buffer_full), 0);
        send(32'h61ABCDEF, 1'b1, 2'd1, 2'd2);
        wait_full(n);
        chk("t5_blockB", out, blk2(32'h611F0000, 32'h00000080));
        chk("t5_lastB", RATE_BITS'(out_last), 1);
        ack();

        // T6: asynchronous reset mid-block
        for (int i = 0; i < 5; i++) send(32'h30000000 + i, 1'b0, 2'd0, 2'd0);
        chk("t6_partial", RATE_BITS'(out[RATE_BITS-1 -: IN_W]), 32'h30000000);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_async_out", out, '0);
        chk("t6_async_full", RATE_BITS'(buffer_full), 0);
        chk("t6_async_ready", RATE_BITS'(out_ready), 0);
        step();
        reset = 1'b1;
        step();
        send(32'h61626300, 1'b1, 2'd3, 2'd1);
        wait_full(n);
        chk("t6_fresh_block", out, blk2(32'h61626306, 32'h00000080));
        chk("t6_fresh_last", RATE_BITS'(out_last), 1);
        ack();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
